uart_tx_fifo: RTL
=================

# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, configurable data width, runtime-selectable parity and one or two stop bits. It accepts words over a valid/ready handshake, buffers up to FIFO_DEPTH words, and serialises them LSB-first on `tx`, one bit per `tx_baud` strobe, with no idle gap between buffered frames. It sits between the host-side data source and the serial pin, driven by the shared baud-tick generator.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5..9.
- `FIFO_DEPTH`, default 16: FIFO entries; power of two, at least 2.
- `CNT_W`, default $clog2(FIFO_DEPTH+1): width of `fifo_count`; derived, do not override.

- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tx_baud`  in  1  one-clock strobe, one per bit period.
- `data_in`  in  DATA_BITS  word to transmit.
- `data_valid`  in  1  `data_in` is valid.
- `data_ready`  out  1  FIFO can accept a word; equals !fifo_full && !reset.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 none; sampled at frame start.
- `stop_two`  in  1  1 = two stop bits, 0 = one; sampled at frame start.
- `tx`  out  1  registered serial output, idle high.
- `tx_busy`  out  1  a frame is in progress (state != IDLE).
- `tx_done`  out  1  one-clock pulse when a frame's last stop bit completes.
- `fifo_count`  out  CNT_W  words currently buffered (0..FIFO_DEPTH).
- `fifo_full` / `fifo_empty`  out  1 each  count == FIFO_DEPTH / count == 0.

## Operation
- Write: a word is stored on any edge where `data_valid && data_ready`. Writes while full are impossible because `data_ready` is 0; `data_valid` with `data_ready` low is ignored, and no word is lost or duplicated.
- Pop: happens only on a frame start. The head word, `parity_mode` and `stop_two` are latched into a frame register. Later input changes do not affect the frame in flight.
- A simultaneous write and pop leaves the count unchanged. A write to an empty FIFO cannot be popped in the same cycle.
- Parity bit (when enabled):
  - even = XOR of the DATA_BITS data bits;
  - odd = its inverse.
- States: IDLE, START, DATA, PARITY, STOP. All transitions occur only on edges where `tx_baud` = 1.
  - IDLE: leave when the FIFO is non-empty → START (pop); `tx` = 1.
  - START: `tx` = 0 → DATA with bit index 0.
  - DATA: `tx` = data[index]. The index increments per tick. After index DATA_BITS-1 → PARITY if parity is enabled, else STOP.
  - PARITY: `tx` = parity bit → STOP.
  - STOP: `tx` = 1 for 1 or 2 bit periods. At the final STOP tick, `tx_done` pulses. The FSM then goes to START with a pop if the FIFO is non-empty (back-to-back), else to IDLE.
- The bit index counter is ceil(log2(DATA_BITS)) bits wide and resets to 0 on every START entry.

## Timing
- Reset values: `tx` = 1, `tx_busy` = 0, `tx_done` = 0, `fifo_count` = 0, `fifo_empty` = 1, `fifo_full` = 0, `data_ready` = 0 while `reset` is high. The FSM goes to IDLE and the FIFO pointers go to 0.
- `data_ready` is 1 on the first cycle after `reset` deasserts.
- Reset mid-frame aborts the frame and flushes the FIFO. `tx` is 1 on the cycle after the reset edge.
- `tx`, `tx_busy` and `tx_done` are registered and change one clock after the `tx_baud` edge that causes the transition.
- Latency: a word written at edge N into an empty FIFO with the FSM in IDLE drives `tx` low one clock after the first `tx_baud` edge at or after N+1.
- Frame length in bit periods is 1 + DATA_BITS + (parity ? 1 : 0) + (stop_two ? 2 : 1).
- Back-to-back frames: the START bit follows the last stop bit with zero idle periods.
- `tx_done` is high for exactly one clock per frame and coincides with `tx_busy` falling, or with the next START bit when back-to-back.
- `fifo_count` updates one clock after the write or pop edge.

## Test plan
- Reset, then write 0xA5 with DATA_BITS=8, parity 00, `stop_two`=0 → `tx` sequence 0,1,0,1,0,0,1,0,1,1 over 10 ticks; one `tx_done` pulse; `tx_busy` falls with it.
- Write 0x0F with parity 01, then again with 10 → parity bit 0 (even), then 1 (odd). With `stop_two`=1 the frame is 12 periods.
- Write FIFO_DEPTH+2 words with `tx_baud` held low → `fifo_full`=1, `data_ready`=0, the extra words are not stored, `fifo_count`=16.
- Write three words, then run ticks → three contiguous frames with no idle bit, three `tx_done` pulses, FIFO empties.
- Assert `reset` during the DATA state of frame 2 of 3 → `tx`=1 the next clock, `fifo_count`=0, no `tx_done`; a new write afterwards transmits correctly.
- Set DATA_BITS=5 and write 0x1F → frame 0,1,1,1,1,1,1; bits above bit 4 are ignored.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a word FIFO: valid/ready write side, LSB-first serial
// output with optional even/odd parity and one or two stop bits.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tx_baud,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic [1:0]           parity_mode,
  input  logic                 stop_two,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [CNT_W-1:0]     fifo_count,
  output logic                 fifo_full,
  output logic                 fifo_empty
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [DATA_BITS-1:0]   frame_q, frame_d;
  logic                   par_en_q, par_en_d;
  logic                   par_bit_q, par_bit_d;
  logic                   stop_two_q, stop_two_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [DATA_BITS-1:0]   head;
  logic                   push;
  logic                   pop;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign data_ready = !fifo_full && !reset;
  assign fifo_count = count_q;
  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign push       = data_valid && data_ready;
  assign head       = mem_q[rd_ptr_q];

  // FIFO storage; pointers and count live with the rest of the state below
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      frame_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop_two_q <= 1'b0;
      stop_cnt_q <= 1'b0;
      idx_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      frame_q    <= frame_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop_two_q <= stop_two_d;
      stop_cnt_q <= stop_cnt_d;
      idx_q      <= idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop_two_d = stop_two_q;
    stop_cnt_d = stop_cnt_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    pop        = 1'b0;
    tx_d       = 1'b1;

    if (tx_baud) begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end
        end
        START: begin
          state_d = DATA;
          idx_d   = '0;
        end
        DATA: begin
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d    = par_en_q ? PARITY : STOP;
            stop_cnt_d = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        PARITY: begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
        end
        STOP: begin
          if (stop_two_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            done_d = 1'b1;
            if (!fifo_empty) begin
              pop = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Frame start: latch head word and line settings so later input changes are ignored
    if (pop) begin
      state_d    = START;
      idx_d      = '0;
      frame_d    = head;
      par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_bit_d  = (^head) ^ (parity_mode == 2'b10);
      stop_two_d = stop_two;
    end

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = frame_d[idx_d];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);

    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

endmodule
